// File: rtl/decrypt_ctrl_if.sv
// Bus bundle between decrypt_ctrl, its two key/ciphertext memories, the
// downstream decrypt accumulator and the plaintext consumer.
//
// Result handshake: result_valid rises once result holds a new value and
// stays high, with result held constant, until a cycle where result_ready is
// also high; the transfer happens on that clock edge. result_ready may be
// asserted before result_valid, and must not be used by the consumer to
// infer that a result exists.
interface decrypt_ctrl_if #(
  parameter int CIPHERTEXT_WIDTH = 10,
  parameter int PLAINTEXT_WIDTH  = 6,
  parameter int DIM_WIDTH        = 4,
  parameter int PARALLEL         = 1
);

  // memory read port (same address to both memories, 1-cycle latency)
  logic                                 mem_rd;
  logic [DIM_WIDTH:0]                   mem_addr;
  logic [CIPHERTEXT_WIDTH*PARALLEL-1:0] mem_sk_rdata;
  logic [CIPHERTEXT_WIDTH*PARALLEL-1:0] mem_ct_rdata;

  // decrypt accumulator stream
  logic                                 dec_en;
  logic [DIM_WIDTH:0]                   dec_row;
  logic [CIPHERTEXT_WIDTH*PARALLEL-1:0] dec_sk_entry;
  logic [CIPHERTEXT_WIDTH*PARALLEL-1:0] dec_ct_entry;
  logic [PLAINTEXT_WIDTH-1:0]           dec_result;

  // plaintext result handshake
  logic [PLAINTEXT_WIDTH-1:0]           result;
  logic                                 result_valid;
  logic                                 result_ready;

  modport master (
    output mem_rd, mem_addr,
    input  mem_sk_rdata, mem_ct_rdata,
    output dec_en, dec_row, dec_sk_entry, dec_ct_entry,
    input  dec_result,
    output result, result_valid,
    input  result_ready
  );

  modport slave (
    input  mem_rd, mem_addr,
    output mem_sk_rdata, mem_ct_rdata,
    input  dec_en, dec_row, dec_sk_entry, dec_ct_entry,
    output dec_result,
    input  result, result_valid,
    output result_ready
  );

endinterface

// File: rtl/decrypt_ctrl.sv
// decrypt_ctrl: sequences one decryption. Reads the key and ciphertext
// memories beat by beat, streams the lanes into the decrypt accumulator with
// en/row framing (tail lanes past DIMENSION forced to zero), then captures the
// low plaintext bits and holds them under a valid/ready handshake.
//
// Optional feature macro: DECRYPT_CTRL_PERF_EN adds a saturating 16-bit
// op_count output counting completed result handshakes.
module decrypt_ctrl #(
  parameter int CIPHERTEXT_WIDTH = 10,
  parameter int PLAINTEXT_WIDTH  = 6,
  parameter int DIMENSION        = 10,
  parameter int DIM_WIDTH        = 4,
  parameter int PARALLEL         = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic [2:0]  dbg_state,
`ifdef DECRYPT_CTRL_PERF_EN
  output logic [15:0] op_count,
`endif
  decrypt_ctrl_if.master bus
);

  localparam int AW    = DIM_WIDTH + 1;
  localparam int LW    = CIPHERTEXT_WIDTH * PARALLEL;
  localparam int BEATS = (DIMENSION + PARALLEL - 1) / PARALLEL;
  localparam logic [AW-1:0] LAST_BEAT = AW'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [AW-1:0]              beat_q, beat_d;
  logic                       mem_rd;
  logic [AW-1:0]              mem_addr;
  logic                       dec_en;
  logic [AW-1:0]              dec_row;
  logic [LW-1:0]              sk_lanes;
  logic [LW-1:0]              ct_lanes;
  logic                       result_valid;
  logic [PLAINTEXT_WIDTH-1:0] result_q;

  // state and beat index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // next-state and framing outputs; the read for beat b+1 is issued during
  // beat b so the memory latency is hidden and STREAM never stalls
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    mem_rd       = 1'b0;
    mem_addr     = '0;
    dec_en       = 1'b0;
    dec_row      = '0;
    result_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_rd  = 1'b1;
        beat_d  = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        dec_en  = 1'b1;
        dec_row = beat_q;
        if (beat_q < LAST_BEAT) begin
          mem_rd   = 1'b1;
          mem_addr = beat_q + 1'b1;
          beat_d   = beat_q + 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        result_valid = 1'b1;
        if (bus.result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // lane pass-through during STREAM; lanes beyond the vector end read as zero
  always_comb begin
    sk_lanes = '0;
    ct_lanes = '0;
    if (state_q == S_STREAM) begin
      for (int j = 0; j < PARALLEL; j++) begin
        if (int'(beat_q) * PARALLEL + j < DIMENSION) begin
          sk_lanes[j*CIPHERTEXT_WIDTH +: CIPHERTEXT_WIDTH] =
            bus.mem_sk_rdata[j*CIPHERTEXT_WIDTH +: CIPHERTEXT_WIDTH];
          ct_lanes[j*CIPHERTEXT_WIDTH +: CIPHERTEXT_WIDTH] =
            bus.mem_ct_rdata[j*CIPHERTEXT_WIDTH +: CIPHERTEXT_WIDTH];
        end
      end
    end
  end

  // capture the finished dot product; held until the next DRAIN
  always_ff @(posedge clk) begin
    if (rst) result_q <= '0;
    else if (state_q == S_DRAIN) result_q <= bus.dec_result;
  end

`ifdef DECRYPT_CTRL_PERF_EN
  logic op_done;
  assign op_done = (state_q == S_HOLD) && bus.result_ready;

  // count completed result handshakes, saturating
  always_ff @(posedge clk) begin
    if (rst) op_count <= '0;
    else if (op_done && (op_count != 16'hFFFF)) op_count <= op_count + 16'd1;
  end
`endif

  assign busy             = (state_q != S_IDLE);
  assign dbg_state        = state_q;
  assign bus.mem_rd       = mem_rd;
  assign bus.mem_addr     = mem_addr;
  assign bus.dec_en       = dec_en;
  assign bus.dec_row      = dec_row;
  assign bus.dec_sk_entry = sk_lanes;
  assign bus.dec_ct_entry = ct_lanes;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid;

endmodule

// File: doc/decrypt_ctrl.md
# decrypt_ctrl

Sequencer that sits directly upstream of the `decrypt` dot-product accumulator.
- On `start`, it reads the secret key and ciphertext vectors from two synchronous-read memories, `PARALLEL` entries per beat.
- It streams them into `decrypt` with the correct `en`/`row` framing and zero-pads unused tail lanes.
- It captures the low plaintext bits of the finished dot product and holds them under a valid/ready handshake until taken.

## Interface
- `CIPHERTEXT_WIDTH`, 10, width of one key/ciphertext entry
- `PLAINTEXT_WIDTH`, 6, result width
- `DIMENSION`, 10, vector length
- `DIM_WIDTH`, 4, bits to index `DIMENSION`
- `PARALLEL`, 1, entries per beat; BEATS = ceil(DIMENSION/PARALLEL)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin one decryption (sampled in IDLE only)
- `busy`  out  1  high in every state except IDLE
- `mem_rd`  out  1  read strobe to both memories
- `mem_addr`  out  DIM_WIDTH+1  beat index; the same address goes to both memories
- `mem_sk_rdata`  in  CIPHERTEXT_WIDTH x PARALLEL  key lanes, valid one cycle after `mem_rd`
- `mem_ct_rdata`  in  CIPHERTEXT_WIDTH x PARALLEL  ciphertext lanes, same timing
- `dec_en`  out  1  to `decrypt.en`
- `dec_row`  out  DIM_WIDTH+1  to `decrypt.row`
- `dec_sk_entry`  out  CIPHERTEXT_WIDTH x PARALLEL  to `decrypt.secretkey_entry`
- `dec_ct_entry`  out  CIPHERTEXT_WIDTH x PARALLEL  to `decrypt.ciphertext_entry`
- `dec_result`  in  PLAINTEXT_WIDTH  from `decrypt.result`
- `result`  out  PLAINTEXT_WIDTH  captured plaintext
- `result_valid`  out  1  `result` holds a new value
- `result_ready`  in  1  consumer accepts `result`

## Operation
- States:
  - IDLE: `start` → FETCH.
  - FETCH: `mem_rd`=1, `mem_addr`=0 → STREAM with beat=0.
  - STREAM(b):
    - `dec_en`=1, `dec_row`=b.
    - Dec entries are driven combinationally from the rdata lanes.
    - If b<BEATS-1: `mem_rd`=1, `mem_addr`=b+1, next beat b+1. Otherwise → DRAIN.
  - DRAIN: `dec_en`=0; register `dec_result` into `result` → HOLD.
  - HOLD: `result_valid`=1; on `result_ready` → IDLE.
- Lane masking: lane j of beat b drives 0 on both `dec_sk_entry` and `dec_ct_entry` when b*PARALLEL+j ≥ DIMENSION, whatever the memory returns.
- `dec_row`=0 on the first beat restarts `decrypt`'s accumulator, so no clear cycle is needed between operations.
- Arithmetic is modulo 2^PLAINTEXT_WIDTH. The controller does no arithmetic; it only takes the low bits.
- Outside STREAM: `dec_en`=0, `dec_row`=0, all dec entries 0.
- Outside FETCH/STREAM: `mem_rd`=0, `mem_addr`=0.
- `start` outside IDLE is ignored (no queuing). This includes `start` in the same cycle as the HOLD handshake.
- `result` is stable from entry into HOLD until the next DRAIN.
- Reset (any state): state IDLE; `busy`, `mem_rd`, `dec_en`, `result_valid` = 0; `mem_addr`, `dec_row`, dec entries, `result` = 0. Reset mid-STREAM aborts with no result.

## Timing
- `start` sampled high at edge 0 → FETCH in cycle 1, STREAM in cycles 2..BEATS+1, DRAIN in cycle BEATS+2, `result_valid` high from cycle BEATS+3.
- Default parameters: `result_valid` rises at cycle 13.
- `result_valid`/`result_ready` handshake completes in the same cycle. IDLE follows, and the earliest accepted next `start` is in that IDLE cycle.
- Memory read latency is exactly one cycle. No stalls inside FETCH/STREAM.
- `decrypt` updates its accumulator at the end of each STREAM cycle. Its `result` is valid during DRAIN.

## Configuration
- `DECRYPT_CTRL_PERF_EN` defined: adds output `op_count` [15:0].
  - Increments on each completed result handshake and saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Defaults; sk all 1, ct[i]=i (0..9); `start` at edge 0, `result_ready`=1 → `dec_row` steps 0..9, `result`=45, `result_valid` at cycle 13, then IDLE.
- PARALLEL=4, DIMENSION=10; sk all 3, ct all 5; memories return 10'h3FF in beat 2 lanes 2–3 → those dec lanes are 0, BEATS=3, `result`=22 (150 mod 64).
- Defaults; all entries 10'h3FF → `result`=10 (10·1023² mod 64); checks wraparound.
- `result_ready` low for 5 cycles in HOLD, with `start` pulsed meanwhile → `result_valid`/`result` stable, `start` ignored, `busy` high. Then ready → IDLE.
- `rst` asserted during STREAM beat 4 → next cycle all outputs 0, IDLE. A new `start` then yields the correct result from row 0.
- With `DECRYPT_CTRL_PERF_EN`: three back-to-back decryptions → `op_count`=3. Reset → 0.
